csrs_access: RTL
================

CSRS_ACCESS -- requirements
Module: csrs_access

Interface
REQ-001 SHALL have parameter READ_TIMEOUT, default 15: max cycles in WAIT for CSR_RVALID before abort.
REQ-002 SHALL have ports, one per line:
  CLK  in  1  sole clock, rising edge
  RST  in  1  reset, asynchronous, active-low
  REQ_VALID  in  1  CSR instruction request
  REQ_READY  out  1  request accepted when both high
  REQ_OP  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
  REQ_ADDR  in  12  CSR address
  REQ_SRC  in  32  rs1 value, or zero-extended uimm for *I ops
  REQ_SRC_NZ  in  1  rs1/uimm field non-zero
  REQ_RD_NZ  in  1  rd != x0
  RES_VALID  out  1  result available
  RES_READY  in  1  result consumed when both high
  RES_DATA  out  32  old CSR value, written to rd
  RES_ERR  out  1  illegal-instruction/timeout flag
  CSR_RDEN  out  1  bank read strobe
  CSR_RADDR  out  12  bank read address
  CSR_RVALID  in  1  bank read data valid
  CSR_RDATA  in  32  bank read data
  CSR_WREN  out  1  bank write strobe
  CSR_WADDR  out  12  bank write address
  CSR_WDATA  out  32  bank write data

Function
REQ-003 SHALL implement FSM IDLE, READ, WAIT, WRITE, RESP; REQ_READY = (state == IDLE).
REQ-004 SHALL latch REQ_OP, REQ_ADDR, REQ_SRC, REQ_SRC_NZ, REQ_RD_NZ on acceptance (cycle T).
REQ-005 SHALL define do_read = !(op in {RW,RWI} && !REQ_RD_NZ); do_write = op in {RW,RWI} || REQ_SRC_NZ.
REQ-006 SHALL flag illegal when REQ_OP in {000,100}, or do_write and REQ_ADDR[11:10] == 2'b11; illegal goes IDLE->RESP at T+1, RES_ERR=1, RES_DATA=0, no bank strobe.
REQ-007 Legal with do_read: IDLE->READ; CSR_RDEN=1 for exactly one cycle (T+1), CSR_RADDR=latched addr; then WAIT.
REQ-008 In WAIT, on CSR_RVALID SHALL capture CSR_RDATA as old value; go WRITE if do_write, else RESP.
REQ-009 In WAIT, counter SHALL start at 0 and increment per cycle; if it reaches READ_TIMEOUT without CSR_RVALID, go RESP with RES_ERR=1, RES_DATA=0, no write.
REQ-010 Legal without do_read: IDLE->WRITE at T+1, old value = 0.
REQ-011 WRITE SHALL assert CSR_WREN for exactly one cycle, CSR_WADDR=latched addr, CSR_WDATA = src (RW/RWI), old|src (RS/RSI), old&~src (RC/RCI); then RESP.
REQ-012 RESP SHALL hold RES_VALID=1 with stable RES_DATA/RES_ERR until RES_READY=1, then IDLE; RES_DATA = old value when !RES_ERR.
REQ-013 With 1-cycle bank latency: full read-modify-write RES_VALID at T+4; read-only at T+3; write-only at T+2.
REQ-014 CSR_RVALID outside WAIT SHALL be ignored.
REQ-015 At most one request in flight; no new request accepted in the RESP-exit cycle (next accept earliest cycle after return to IDLE).

Reset
REQ-016 RST low SHALL force, asynchronously, state=IDLE, counter=0, latched fields=0, and all outputs low/zero except REQ_READY, which SHALL be 1 after release.
REQ-017 Reset mid-operation SHALL abandon the request: no CSR_WREN pulse after reset assertion, no RES_VALID for it.

Structure
REQ-018 Shared package csrs_pkg SHALL hold funct3 op encodings, FSM state encoding, the read-only address field constant (2'b11) and the 32-bit data width.
REQ-019 New-value computation SHALL be sub-module csrs_alu (combinational: op, old, src -> wdata); FSM and counter stay in csrs_access.

Verification
REQ-020 RS, addr 0x300, bank old 0x0000_00F0, src 0x0F -> CSR_WDATA 0x0000_00FF, RES_DATA 0x0000_00F0, RES_VALID at T+4.
REQ-021 RW, rd=x0, addr 0x340, src 0xDEAD_BEEF -> no CSR_RDEN, CSR_WREN at T+1, RES_VALID T+2, RES_DATA 0.
REQ-022 RC, REQ_SRC_NZ=0, addr 0xC00 -> read only, no CSR_WREN, RES_ERR=0, RES_VALID T+3.
REQ-023 RW to 0xC01 -> RES_ERR=1 at T+1, no bank strobes; REQ_OP=100 -> same.
REQ-024 Bank never asserts CSR_RVALID -> RES_ERR=1 after 15 WAIT cycles, no write; RES_READY held low 5 cycles -> outputs stable.
REQ-025 RST low during WAIT -> REQ_READY=1, no CSR_WREN, no RES_VALID; next RS completes normally.

Source files
------------

// File: rtl/csrs_pkg.sv
// Shared definitions for the CSR access sequencer: funct3 encodings, FSM states,
// the read-only address field and the data width.
package csrs_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_RW  = 3'b001;
  localparam logic [2:0] OP_RS  = 3'b010;
  localparam logic [2:0] OP_RC  = 3'b011;
  localparam logic [2:0] OP_RWI = 3'b101;
  localparam logic [2:0] OP_RSI = 3'b110;
  localparam logic [2:0] OP_RCI = 3'b111;

  // CSR addresses with [11:10] == 2'b11 are read-only
  localparam logic [1:0] RO_FIELD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  function automatic logic op_is_swap(input logic [2:0] op);
    return (op == OP_RW) || (op == OP_RWI);
  endfunction

  function automatic logic op_is_legal(input logic [2:0] op);
    return op_is_swap(op) || (op == OP_RS) || (op == OP_RC) ||
           (op == OP_RSI) || (op == OP_RCI);
  endfunction

  // A swap into x0 skips the read so the CSR sees no read side effects
  function automatic logic csr_do_read(input logic [2:0] op, input logic rd_nz);
    return !(op_is_swap(op) && !rd_nz);
  endfunction

  function automatic logic csr_do_write(input logic [2:0] op, input logic src_nz);
    return op_is_swap(op) || src_nz;
  endfunction

endpackage

// File: rtl/csrs_alu.sv
// New CSR value from the old value and the source operand (swap / set / clear).
module csrs_alu
  import csrs_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] src,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    wdata = '0;
    case (op)
      OP_RW, OP_RWI: wdata = src;
      OP_RS, OP_RSI: wdata = old | src;
      OP_RC, OP_RCI: wdata = old & ~src;
      default:       wdata = '0;
    endcase
  end

endmodule

// File: rtl/csrs_access.sv
// CSR instruction sequencer: read, modify and write one CSR bank entry per request.
//
// state | meaning
// IDLE  | ready for a request
// READ  | one-cycle bank read strobe
// WAIT  | waiting for bank read data, bounded by READ_TIMEOUT
// WRITE | one-cycle bank write strobe with the new value
// RESP  | result held until consumed
module csrs_access
  import csrs_pkg::*;
#(
  parameter int READ_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_OP,
  input  logic [11:0]       REQ_ADDR,
  input  logic [DATA_W-1:0] REQ_SRC,
  input  logic              REQ_SRC_NZ,
  input  logic              REQ_RD_NZ,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [DATA_W-1:0] RES_DATA,
  output logic              RES_ERR,
  output logic              CSR_RDEN,
  output logic [11:0]       CSR_RADDR,
  input  logic              CSR_RVALID,
  input  logic [DATA_W-1:0] CSR_RDATA,
  output logic              CSR_WREN,
  output logic [11:0]       CSR_WADDR,
  output logic [DATA_W-1:0] CSR_WDATA
);

  localparam int CW = $clog2(READ_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(READ_TIMEOUT - 1);

  state_t            state;
  logic [2:0]        op_q;
  logic [11:0]       addr_q;
  logic [DATA_W-1:0] src_q;
  logic [DATA_W-1:0] old_q;
  logic              src_nz_q;
  logic              rd_nz_q;
  logic [CW-1:0]     wait_cnt;

  logic              req_do_read;
  logic              req_do_write;
  logic              req_illegal;
  logic              do_read_q;
  logic              do_write_q;

  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_old;
  logic [DATA_W-1:0] alu_src;
  logic [DATA_W-1:0] alu_wdata;

  assign req_do_read  = csr_do_read(REQ_OP, REQ_RD_NZ);
  assign req_do_write = csr_do_write(REQ_OP, REQ_SRC_NZ);
  assign req_illegal  = !op_is_legal(REQ_OP) ||
                        (req_do_write && (REQ_ADDR[11:10] == RO_FIELD));
  assign do_read_q    = csr_do_read(op_q, rd_nz_q);
  assign do_write_q   = csr_do_write(op_q, src_nz_q);

  // Write-only requests compute straight from the inputs with an old value of zero
  assign alu_op  = (state == ST_IDLE) ? REQ_OP  : op_q;
  assign alu_src = (state == ST_IDLE) ? REQ_SRC : src_q;
  assign alu_old = (state == ST_WAIT) ? CSR_RDATA : '0;

  csrs_alu u_alu (
    .op    (alu_op),
    .old   (alu_old),
    .src   (alu_src),
    .wdata (alu_wdata)
  );

  assign REQ_READY = (state == ST_IDLE);
  assign CSR_RADDR = addr_q;
  assign CSR_WADDR = addr_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      src_q     <= '0;
      old_q     <= '0;
      src_nz_q  <= 1'b0;
      rd_nz_q   <= 1'b0;
      wait_cnt  <= '0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      RES_ERR   <= 1'b0;
      CSR_RDEN  <= 1'b0;
      CSR_WREN  <= 1'b0;
      CSR_WDATA <= '0;
    end else begin
      CSR_RDEN <= 1'b0;
      CSR_WREN <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            op_q     <= REQ_OP;
            addr_q   <= REQ_ADDR;
            src_q    <= REQ_SRC;
            src_nz_q <= REQ_SRC_NZ;
            rd_nz_q  <= REQ_RD_NZ;
            old_q    <= '0;
            wait_cnt <= '0;
            if (req_illegal) begin
              state     <= ST_RESP;
              RES_VALID <= 1'b1;
              RES_ERR   <= 1'b1;
              RES_DATA  <= '0;
            end else if (req_do_read) begin
              state    <= ST_READ;
              CSR_RDEN <= 1'b1;
            end else begin
              state     <= ST_WRITE;
              CSR_WREN  <= 1'b1;
              CSR_WDATA <= alu_wdata;
            end
          end
        end
        ST_READ: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (CSR_RVALID && do_read_q) begin
            old_q <= CSR_RDATA;
            if (do_write_q) begin
              state     <= ST_WRITE;
              CSR_WREN  <= 1'b1;
              CSR_WDATA <= alu_wdata;
            end else begin
              state     <= ST_RESP;
              RES_VALID <= 1'b1;
              RES_ERR   <= 1'b0;
              RES_DATA  <= CSR_RDATA;
            end
          end else if (wait_cnt == TO_LAST) begin
            state     <= ST_RESP;
            RES_VALID <= 1'b1;
            RES_ERR   <= 1'b1;
            RES_DATA  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          state     <= ST_RESP;
          RES_VALID <= 1'b1;
          RES_ERR   <= 1'b0;
          RES_DATA  <= old_q;
        end
        ST_RESP: begin
          if (RES_READY) begin
            state     <= ST_IDLE;
            RES_VALID <= 1'b0;
            RES_ERR   <= 1'b0;
            RES_DATA  <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
